// File: rtl/instr_issue_if.sv
// ============================================================================
// instr_issue_if : loader push channel and issue bus of the instruction issue unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] ibus;
  logic        issue_valid;
  logic [15:0] bubble_cnt;

  // slave: the issue unit itself; master: the loader/controller environment
  modport slave (
    input  in_valid, in_instr,
    output in_ready, ibus, issue_valid, bubble_cnt
  );

  modport master (
    output in_valid, in_instr,
    input  in_ready, ibus, issue_valid, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/instr_issue.sv
// ============================================================================
// instr_issue : FIFO-fed instruction issue with RAW-hazard NOP bubble insertion.
// Optional macro ISSUE_BUBBLE_CNT_EN enables the saturating hazard-stall counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_issue #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_issue_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    hist [HAZ_DEPTH];
  logic [31:0]   ibus_r;
  logic          valid_r;

  logic [31:0]   head;
  logic [4:0]    src_a;
  logic [4:0]    src_b;
  logic [4:0]    dest;
  logic          haz_any;
  logic          hazard;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr];

  assign bus.in_ready    = !full;
  assign bus.ibus        = ibus_r;
  assign bus.issue_valid = valid_r;

  // I-type has a single source; a zero second source can never match history
  always_comb begin
    src_a = head[25:21];
    src_b = 5'd0;
    dest  = head[20:16];
    if (head[31:26] == 6'd0) begin
      src_b = head[20:16];
      dest  = head[15:11];
    end
  end

  always_comb begin
    haz_any = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (hist[i] != 5'd0 && (hist[i] == src_a || hist[i] == src_b))
        haz_any = 1'b1;
    end
  end

  assign hazard = haz_any;
  assign issue  = !empty && !hazard;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ibus_r  <= 32'h0;
      valid_r <= 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++)
        hist[i] <= 5'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (issue)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, issue})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      ibus_r  <= issue ? head : 32'h0;
      valid_r <= issue;

      // a bubble shifts in a zero destination so the hazard window drains
      for (int i = HAZ_DEPTH - 1; i > 0; i--)
        hist[i] <= hist[i-1];
      hist[0] <= issue ? dest : 5'd0;
    end
  end

`ifdef ISSUE_BUBBLE_CNT_EN
  logic [15:0] bub_r;

  // empty-FIFO bubbles are idle time, not stalls, so they are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bub_r <= 16'h0;
    else if (!empty && hazard && bub_r != 16'hFFFF)
      bub_r <= bub_r + 16'd1;
  end

  assign bus.bubble_cnt = bub_r;
`else
  assign bus.bubble_cnt = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_issue.sv
// ============================================================================
// tb_instr_issue : scoreboard bench for instr_issue (DEPTH=4, HAZ_DEPTH=3)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_issue;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_issue_if bus ();

  instr_issue #(.DEPTH(4), .HAZ_DEPTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    int          gap;     // expected bubbles since previous issue, -1 = don't care
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gap      = 0;

`ifdef ISSUE_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] A  = 32'h00221803;  // R rs1 rt2 rd3
  localparam logic [31:0] B  = 32'h0C850007;  // I rs4 rt5
  localparam logic [31:0] C  = 32'h0C640005;  // I rs3 rt4 (depends on A)
  localparam logic [31:0] D  = 32'h00220003;  // R rd0
  localparam logic [31:0] E  = 32'h0C040001;  // I rs0
  localparam logic [31:0] F1 = 32'h04C70001;
  localparam logic [31:0] F2 = 32'h05090002;
  localparam logic [31:0] F3 = 32'h054B0003;
  localparam logic [31:0] F4 = 32'h058D0004;
  localparam logic [31:0] G1 = 32'h04220001;
  localparam logic [31:0] G2 = 32'h04640002;
  localparam logic [31:0] G3 = 32'h04A60003;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [31:0] w, input int g);
    exp_t e;
    e.instr = w;
    e.gap   = g;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push(input logic [31:0] w, output int edges);
    logic ok;
    ok    = 1'b0;
    edges = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    for (int t = 0; t < 50; t++) begin
      ok = bus.in_ready;
      @(negedge clk);
      edges++;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: word %h not accepted", w);
    end
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 60 && sb.size() != 0; t++)
      @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // Monitor: every valid cycle pops the scoreboard; every bubble must be a NOP
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      gap = 0;
    end else if (bus.issue_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got %h expected no issue", bus.ibus);
      end else begin
        e = sb.pop_front();
        check("issue_word", bus.ibus, e.instr);
        if (e.gap >= 0)
          check("issue_gap", 32'(gap), 32'(e.gap));
      end
      gap = 0;
    end else begin
      check("bubble_nop", bus.ibus, 32'h0);
      gap++;
    end
  end

  initial begin
    int e;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ibus", bus.ibus, 32'h0);
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset mid-stream, G3 still queued must never issue
    expect_issue(G1, -1);
    expect_issue(G2, 0);
    push(G1, e);
    push(G2, e);
    push(G3, e);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ibus", bus.ibus, 32'h0);
    check("midrst_valid", 32'(bus.issue_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // 2: independent back-to-back
    expect_issue(A, -1);
    expect_issue(B, 0);
    push(A, e);
    push(B, e);
    drain();

    // 3: RAW hazard, three bubbles
    expect_issue(A, -1);
    expect_issue(C, 3);
    push(A, e);
    push(C, e);
    drain();
    check("bubble_cnt_raw", 32'(bus.bubble_cnt), CNT_EN ? 32'd3 : 32'd0);

    // 4: register 0 never hazards
    expect_issue(D, -1);
    expect_issue(E, 0);
    push(D, e);
    push(E, e);
    drain();

    // 5: fill FIFO behind a stalled head
    expect_issue(A, -1);
    expect_issue(C, 3);
    expect_issue(F1, 0);
    expect_issue(F2, 0);
    expect_issue(F3, 0);
    expect_issue(F4, 0);
    push(A, e);
    push(C, e);
    push(F1, e);
    push(F2, e);
    push(F3, e);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    push(F4, e);
    check("fifth_accept_edges", 32'(e), 32'd2);
    drain();
    check("bubble_cnt_full", 32'(bus.bubble_cnt), CNT_EN ? 32'd6 : 32'd0);

`ifdef ISSUE_BUBBLE_CNT_EN
    // 6: persistent hazard drives the counter into saturation
    force dut.hazard = 1'b1;
    expect_issue(G1, -1);
    push(G1, e);
    repeat (65540) @(negedge clk);
    check("bubble_cnt_sat", 32'(bus.bubble_cnt), 32'h0000FFFF);
    release dut.hazard;
    drain();
    check("bubble_cnt_hold", 32'(bus.bubble_cnt), 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
